// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction feeder: instruction field layout,
// opcode codes, FSM state encoding and small decode helpers.
package inst_fetch_pkg;

  localparam int unsigned WORD_W = 16;

  // Opcode field [15:13]
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  function automatic logic [2:0] get_opcode(input logic [WORD_W-1:0] word);
    return word[15:13];
  endfunction

  function automatic logic get_imm_flag(input logic [WORD_W-1:0] word);
    return word[12];
  endfunction

  function automatic logic [2:0] get_rx(input logic [WORD_W-1:0] word);
    return word[11:9];
  endfunction

  function automatic logic [2:0] get_ry(input logic [WORD_W-1:0] word);
    return word[2:0];
  endfunction

  // A word whose opcode is the halt marker stops the feeder and is never issued.
  function automatic logic is_halt(input logic [WORD_W-1:0] word);
    return (word[15:13] == OP_HALT);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Host/processor-facing bus of the instruction feeder. The master side is the
// feeder itself; the slave side is whatever drives Start/Done/program load.
interface inst_fetch_if #(
  parameter int ADDR_W = 5
);

  logic              start;
  logic              done;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [15:0]       ld_data;
  logic [15:0]       din;
  logic              run;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       instr_count;
  logic              halted;

  modport master (
    input  start, done, ld_en, ld_addr, ld_data,
    output din, run, pc, instr_count, halted
  );

  modport slave (
    output start, done, ld_en, ld_addr, ld_data,
    input  din, run, pc, instr_count, halted
  );

endinterface

// File: rtl/inst_fetch_mem.sv
// Program store: 2**ADDR_W x 16, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset so a loaded
// program survives a processor reset.
module inst_mem
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Program-load write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction feeder: presents mem[PC] to the processor, pulses Run for one
// cycle per instruction, waits for Done, and stops on a halt marker or at the
// end of memory (unless WRAP is set).
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter bit WRAP   = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  inst_fetch_if.master  io_bus
);

  localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PC_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [15:0]       r_count;
  logic [15:0]       w_count_nxt;
  logic              r_halted;
  logic              w_run;
  logic              w_mem_we;
  logic [15:0]       w_word;

  // Loads are only accepted while nothing is executing, so the program can
  // never change underneath a running sequence. A load on the same edge as
  // Start still commits before ISSUE reads the word.
  assign w_mem_we = io_bus.ld_en && ((r_state == ST_IDLE) || (r_state == ST_HALT));

  inst_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_mem_we),
    .i_waddr (io_bus.ld_addr),
    .i_wdata (io_bus.ld_data),
    .i_raddr (r_pc),
    .o_rdata (w_word)
  );

  // State, PC, instruction counter and Halted flag registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_pc     <= PC_ZERO;
      r_count  <= 16'd0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_count  <= w_count_nxt;
      r_halted <= (w_state_nxt == ST_HALT);
    end
  end

  // Next-state, next-PC, counter update and Run decode
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_count_nxt = r_count;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (io_bus.start) begin
          w_state_nxt = ST_ISSUE;
          w_pc_nxt    = PC_ZERO;
          w_count_nxt = 16'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_ISSUE: begin
        // The processor is in T0 and latches DIN this edge; a halt marker
        // is withheld so it is neither executed nor counted.
        if (is_halt(w_word)) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_run       = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (io_bus.done) begin
          w_count_nxt = r_count + 16'd1;
          if ((r_pc == PC_LAST) && (WRAP == 1'b0)) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_pc_nxt    = r_pc + PC_ONE;
            w_state_nxt = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign io_bus.din         = w_word;
  assign io_bus.run         = w_run;
  assign io_bus.pc          = r_pc;
  assign io_bus.instr_count = r_count;
  assign io_bus.halted      = r_halted;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: two instances (WRAP=0 and WRAP=1) share the host-side
// stimulus; each has its own behavioural processor model. Issued instructions
// are scored against a queue filled from the bench's own program image.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int AW    = 5;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [15:0]   word;
  } issue_t;

  typedef struct {
    int prog;
    int exp_pc;
    int exp_cnt;
    int exp_r0;
    bit chk_r0;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start, ld_en, force_done;
  logic [AW-1:0] ld_addr;
  logic [15:0]   ld_data;
  logic          pdone [2];

  inst_fetch_if #(.ADDR_W(AW)) bus0 ();
  inst_fetch_if #(.ADDR_W(AW)) bus1 ();

  inst_fetch #(.ADDR_W(AW), .WRAP(1'b0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus0));
  inst_fetch #(.ADDR_W(AW), .WRAP(1'b1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus1));

  assign bus0.start = start;   assign bus1.start = start;
  assign bus0.ld_en = ld_en;   assign bus1.ld_en = ld_en;
  assign bus0.ld_addr = ld_addr; assign bus1.ld_addr = ld_addr;
  assign bus0.ld_data = ld_data; assign bus1.ld_data = ld_data;
  assign bus0.done = pdone[0] | force_done;
  assign bus1.done = pdone[1] | force_done;

  logic          run_s  [2];
  logic [15:0]   din_s  [2];
  logic [AW-1:0] pc_s   [2];
  logic [15:0]   cnt_s  [2];
  logic          halt_s [2];
  assign run_s[0] = bus0.run;          assign run_s[1] = bus1.run;
  assign din_s[0] = bus0.din;          assign din_s[1] = bus1.din;
  assign pc_s[0]  = bus0.pc;           assign pc_s[1]  = bus1.pc;
  assign cnt_s[0] = bus0.instr_count;  assign cnt_s[1] = bus1.instr_count;
  assign halt_s[0] = bus0.halted;      assign halt_s[1] = bus1.halted;

  int checks = 0;
  int errors = 0;

  issue_t      sb0 [$];
  issue_t      sb1 [$];
  logic [15:0] model_mem [DEPTH];

  // processor model state
  logic        busy [2];
  int          cd   [2];
  int          gap  [2];
  logic [15:0] ir   [2];
  logic [15:0] regs [2][8];
  issue_t      sb_e;
  logic        sb_got;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic exec_instr(input int i);
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] opnd;
    rx   = get_rx(ir[i]);
    ry   = get_ry(ir[i]);
    opnd = get_imm_flag(ir[i]) ? {7'd0, ir[i][8:0]} : regs[i][ry];
    case (get_opcode(ir[i]))
      OP_MV:   regs[i][rx] = opnd;
      OP_MVT:  regs[i][rx] = {ir[i][7:0], 8'd0};
      OP_ADD:  regs[i][rx] = regs[i][rx] + opnd;
      OP_SUB:  regs[i][rx] = regs[i][rx] - opnd;
      default: regs[i][rx] = regs[i][rx];
    endcase
  endtask

  // Processor model: latches DIN when Run is seen, raises Done after a delay
  // taken from the word's low bits, executes after its Done edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          busy[i] = 1'b0; pdone[i] = 1'b0; cd[i] = 0; gap[i] = 0;
          for (int r = 0; r < 8; r++) regs[i][r] = 16'd0;
        end else begin
          gap[i] = gap[i] + 1;
          if (pdone[i]) begin
            exec_instr(i);
            pdone[i] = 1'b0;
            busy[i]  = 1'b0;
          end
          if (run_s[i]) begin
            check($sformatf("run_latency%0d", i), gap[i], 1);
            sb_got = 1'b0;
            if (i == 0 && sb0.size() > 0) begin sb_e = sb0.pop_front(); sb_got = 1'b1; end
            if (i == 1 && sb1.size() > 0) begin sb_e = sb1.pop_front(); sb_got = 1'b1; end
            if (!sb_got) begin
              checks++; errors++;
              $display("FAIL unexpected_run%0d: Run at pc %0d, none expected", i, pc_s[i]);
            end else begin
              check($sformatf("issue_pc%0d", i), int'(pc_s[i]), int'(sb_e.pc));
              check($sformatf("issue_word%0d", i), int'(din_s[i]), int'(sb_e.word));
            end
            ir[i]   = din_s[i];
            busy[i] = 1'b1;
            cd[i]   = int'(din_s[i][1:0]);
          end else if (busy[i] && !pdone[i]) begin
            if (cd[i] == 0) begin
              pdone[i] = 1'b1;
              gap[i]   = 0;
            end else begin
              cd[i] = cd[i] - 1;
            end
          end
          if (start) gap[i] = 0;
        end
      end
    end
  end

  task automatic build_prog(input int kind);
    for (int a = 0; a < DEPTH; a++) begin
      case (kind)
        0: begin
          case (a)
            0:       model_mem[a] = 16'h1005;
            1:       model_mem[a] = 16'h5003;
            2:       model_mem[a] = 16'h6201;
            default: model_mem[a] = 16'hE000;
          endcase
        end
        1: model_mem[a] = (a == 0) ? 16'h1000 : ((a == 31) ? 16'hE000 : 16'h5001);
        2: model_mem[a] = (a == 0) ? 16'hE000 : 16'h5001;
        3: model_mem[a] = (a == 0) ? 16'h1000 : ((a == 10) ? 16'hE000 : 16'h5001);
        default: model_mem[a] = 16'h5001;
      endcase
    end
  endtask

  task automatic load_prog();
    for (int a = 0; a < DEPTH; a++) begin
      ld_en = 1'b1; ld_addr = AW'(a); ld_data = model_mem[a];
      tick();
    end
    ld_en = 1'b0;
  endtask

  // Expected issue sequence for each instance from the bench's image
  task automatic push_expected();
    int p;
    issue_t e;
    for (int w = 0; w < 2; w++) begin
      p = 0;
      for (int n = 0; n < 64; n++) begin
        if (model_mem[p][15:13] == 3'b111) break;
        e.pc = AW'(p); e.word = model_mem[p];
        if (w == 0) sb0.push_back(e); else sb1.push_back(e);
        if (w == 0 && p == DEPTH - 1) break;
        p = (p + 1) % DEPTH;
      end
    end
  endtask

  task automatic start_run();
    push_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halted(input string name);
    int n;
    n = 0;
    while (!(halt_s[0] && halt_s[1]) && n < 500) begin tick(); n++; end
    if (!(halt_s[0] && halt_s[1])) fail(name);
  endtask

  task automatic wait_in_wait(input int cnt, input string name);
    int n;
    n = 0;
    while (!(cnt_s[0] == 16'(cnt) && busy[0] && !run_s[0]) && n < 100) begin tick(); n++; end
    if (!(cnt_s[0] == 16'(cnt) && busy[0] && !run_s[0])) fail(name);
  endtask

  task automatic check_both(input string tag, input int epc, input int ecnt, input int ehalt);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_pc%0d", tag, i), int'(pc_s[i]), epc);
      check($sformatf("%s_cnt%0d", tag, i), int'(cnt_s[i]), ecnt);
      check($sformatf("%s_halted%0d", tag, i), int'(halt_s[i]), ehalt);
      check($sformatf("%s_run%0d", tag, i), int'(run_s[i]), 0);
    end
  endtask

  task automatic check_r0(input string tag, input int exp);
    check($sformatf("%s_r0_0", tag), int'(regs[0][0]), exp);
    check($sformatf("%s_r0_1", tag), int'(regs[1][0]), exp);
    check($sformatf("%s_sb0_left", tag), sb0.size(), 0);
    check($sformatf("%s_sb1_left", tag), sb1.size(), 0);
  endtask

  vec_t vecs [4];
  int   seen, n, pc_at32, halt_at32;

  initial begin
    vecs[0] = '{0, 3, 3, 8, 1'b1};
    vecs[1] = '{1, 31, 31, 30, 1'b1};
    vecs[2] = '{2, 0, 0, 0, 1'b0};
    vecs[3] = '{3, 10, 10, 9, 1'b1};

    start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = 16'd0; force_done = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    check_both("reset", 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // spurious Done in IDLE
    force_done = 1'b1; tick(); force_done = 1'b0; tick();
    check_both("idle_done", 0, 0, 0);

    // table-driven programs
    for (int t = 0; t < 4; t++) begin
      build_prog(vecs[t].prog);
      load_prog();
      start_run();
      wait_halted($sformatf("halt_timeout_v%0d", t));
      tick();
      check_both($sformatf("v%0d", t), vecs[t].exp_pc, vecs[t].exp_cnt, 1);
      check($sformatf("v%0d_sb0_left", t), sb0.size(), 0);
      check($sformatf("v%0d_sb1_left", t), sb1.size(), 0);
      if (vecs[t].chk_r0) check_r0($sformatf("v%0d", t), vecs[t].exp_r0);
    end

    // spurious Done in HALT
    force_done = 1'b1; tick(); force_done = 1'b0; tick();
    check_both("halt_done", 10, 10, 1);

    // load and Start on the same edge: ISSUE sees the freshly written marker
    model_mem[0] = 16'hE000;
    push_expected();
    ld_en = 1'b1; ld_addr = '0; ld_data = 16'hE000; start = 1'b1;
    tick();
    ld_en = 1'b0; start = 1'b0;
    tick(); tick();
    check_both("ld_start", 0, 0, 1);

    // all-add program: WRAP=0 halts at the end, WRAP=1 wraps to 0
    build_prog(4);
    load_prog();
    start_run();
    seen = 0; n = 0; pc_at32 = -1; halt_at32 = -1;
    while (!(halt_s[0] && seen == 1) && n < 600) begin
      tick(); n++;
      if (seen == 0 && cnt_s[1] == 16'd32) begin
        seen = 1; pc_at32 = int'(pc_s[1]); halt_at32 = int'(halt_s[1]);
      end
    end
    if (!(halt_s[0] && seen == 1)) fail("wrap_timeout");
    check("nowrap_pc", int'(pc_s[0]), 31);
    check("nowrap_cnt", int'(cnt_s[0]), 32);
    check("nowrap_halted", int'(halt_s[0]), 1);
    check("nowrap_sb_left", sb0.size(), 0);
    check("wrap_pc_at32", pc_at32, 0);
    check("wrap_halted_at32", halt_at32, 0);
    rst_n = 1'b0; tick();
    check_both("wrap_reset", 0, 0, 0);
    rst_n = 1'b1; sb0.delete(); sb1.delete(); tick();

    // load attempt during WAIT is ignored
    build_prog(0);
    load_prog();
    start_run();
    wait_in_wait(0, "ldwait_timeout");
    ld_en = 1'b1; ld_addr = AW'(1); ld_data = 16'hE000;
    tick();
    ld_en = 1'b0;
    wait_halted("ldwait_halt_timeout");
    tick();
    check_both("ldwait", 3, 3, 1);
    check_r0("ldwait", 8);

    // Start during WAIT is ignored
    start_run();
    wait_in_wait(1, "stwait_timeout");
    start = 1'b1; tick(); start = 1'b0;
    wait_halted("stwait_halt_timeout");
    tick();
    check_both("stwait", 3, 3, 1);
    check_r0("stwait", 8);

    // reset during WAIT of instruction 2, then rerun the intact program
    start_run();
    wait_in_wait(1, "rstwait_timeout");
    rst_n = 1'b0; tick();
    check_both("rstwait", 0, 0, 0);
    rst_n = 1'b1; sb0.delete(); sb1.delete(); tick();
    start_run();
    wait_halted("rerun_halt_timeout");
    tick();
    check_both("rerun", 3, 3, 1);
    check_r0("rerun", 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
